// File: rtl/ctrl_link_arbiter.sv
// Round-robin arbiter and four-phase strobe/ack sequencer for the serial control link master.
// One register transaction is outstanding at a time; a timeout or a link drop ends it with err.
module ctrl_link_arbiter #(
  parameter int          N_REQ   = 4,
  parameter logic [15:0] TIMEOUT = 16'd4096
) (
  input  logic                  byte_clk,
  input  logic                  reset_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      req_we,
  input  logic [16*N_REQ-1:0]   req_addr,
  input  logic [32*N_REQ-1:0]   req_wdata,
  output logic [N_REQ-1:0]      done,
  output logic [N_REQ-1:0]      err,
  output logic [31:0]           rdata,
  output logic                  busy,
  output logic                  link_strobe,
  output logic                  link_we,
  output logic [15:0]           link_addr,
  output logic [31:0]           link_wdata,
  input  logic                  link_ack,
  input  logic [31:0]           link_rdata,
  input  logic                  link_ok
);

  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_RELEASE = 3'd2,
    S_DONE    = 3'd3,
    S_FAIL    = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        count_q, count_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic               busy_q, busy_d;
  logic               strobe_q, strobe_d;
  logic               we_q, we_d;
  logic [15:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic [N_REQ-1:0]   err_q, err_d;

  logic               found_s;
  logic               hit_s;
  logic [IDX_W-1:0]   pick_s;
  logic [IDX_W:0]     sum_s;
  logic               sel_we_s;
  logic [15:0]        sel_addr_s;
  logic [31:0]        sel_wdata_s;
  logic [N_REQ-1:0]   grant_onehot_s;
  logic               timeout_s;

  // Round-robin search: first set request starting one past the last grant, wrapping modulo N_REQ.
  always_comb begin
    found_s = 1'b0;
    hit_s   = 1'b0;
    pick_s  = '0;
    sum_s   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      sum_s   = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      sum_s   = (sum_s >= (IDX_W+1)'(N_REQ)) ? sum_s - (IDX_W+1)'(N_REQ) : sum_s;
      hit_s   = !found_s && req[sum_s[IDX_W-1:0]];
      pick_s  = hit_s ? sum_s[IDX_W-1:0] : pick_s;
      found_s = found_s | hit_s;
    end
  end

  // Mux out the picked requester's transaction fields.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = 16'h0000;
    sel_wdata_s = 32'h0000_0000;
    for (int i = 0; i < N_REQ; i++) begin
      sel_we_s    = (pick_s == IDX_W'(i)) ? req_we[i]              : sel_we_s;
      sel_addr_s  = (pick_s == IDX_W'(i)) ? req_addr[16*i +: 16]   : sel_addr_s;
      sel_wdata_s = (pick_s == IDX_W'(i)) ? req_wdata[32*i +: 32]  : sel_wdata_s;
    end
  end

  assign grant_onehot_s = {{(N_REQ-1){1'b0}}, 1'b1} << grant_q;
  assign timeout_s      = (count_q == TIMEOUT - 16'd1);

  // Next-state and registered-output logic; link_ok loss outranks ack and timeout.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    busy_d   = busy_q;
    strobe_d = strobe_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    done_d   = '0;
    err_d    = '0;
    case (state_q)
      S_IDLE: begin
        if (link_ok && !link_ack && found_s) begin
          state_d  = S_ISSUE;
          grant_d  = pick_s;
          rr_ptr_d = pick_s;
          busy_d   = 1'b1;
          strobe_d = 1'b1;
          we_d     = sel_we_s;
          addr_d   = sel_addr_s;
          wdata_d  = sel_wdata_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (!link_ok || (!link_ack && timeout_s)) begin
          state_d  = S_FAIL;
          strobe_d = 1'b0;
          err_d    = grant_onehot_s;
        end else if (link_ack) begin
          state_d  = S_RELEASE;
          strobe_d = 1'b0;
          rdata_d  = we_q ? rdata_q : link_rdata;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_RELEASE: begin
        if (!link_ok || (link_ack && timeout_s)) begin
          state_d = S_FAIL;
          err_d   = grant_onehot_s;
        end else if (!link_ack) begin
          state_d = S_DONE;
          done_d  = grant_onehot_s;
        end else begin
          state_d = S_RELEASE;
        end
      end
      S_DONE, S_FAIL: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d  = S_IDLE;
        busy_d   = 1'b0;
        strobe_d = 1'b0;
      end
    endcase
    count_d = ((state_d != state_q) || (state_q == S_IDLE)) ? 16'd0 : count_q + 16'd1;
  end

  // State and output registers.
  always_ff @(posedge byte_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      count_q  <= 16'd0;
      rr_ptr_q <= IDX_W'(N_REQ-1);
      grant_q  <= '0;
      busy_q   <= 1'b0;
      strobe_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 16'h0000;
      wdata_q  <= 32'h0000_0000;
      rdata_q  <= 32'h0000_0000;
      done_q   <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      strobe_q <= strobe_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign done        = done_q;
  assign err         = err_q;
  assign rdata       = rdata_q;
  assign busy        = busy_q;
  assign link_strobe = strobe_q;
  assign link_we     = we_q;
  assign link_addr   = addr_q;
  assign link_wdata  = wdata_q;

endmodule

// File: tb/tb_ctrl_link_arbiter.sv
// Directed bench for ctrl_link_arbiter: reset, round robin, write, read, timeout, link loss, mid-op reset.
module tb_ctrl_link_arbiter;

  localparam int N = 4;

  logic          byte_clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  req, req_we;
  logic [16*N-1:0] req_addr;
  logic [32*N-1:0] req_wdata;
  logic [N-1:0]  done, err;
  logic [31:0]   rdata;
  logic          busy, link_strobe, link_we;
  logic [15:0]   link_addr;
  logic [31:0]   link_wdata;
  logic          link_ack, link_ok;
  logic [31:0]   link_rdata;

  int checks = 0;
  int errors = 0;

  logic          obs_ok;
  logic [15:0]   obs_addr;
  logic [31:0]   obs_wdata, obs_rdata;
  logic          obs_we, obs_busy_next;
  logic [N-1:0]  obs_done, obs_err, obs_done_next;

  ctrl_link_arbiter #(.N_REQ(N), .TIMEOUT(16'd16)) dut (
    .byte_clk(byte_clk), .reset_n(reset_n),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .done(done), .err(err), .rdata(rdata), .busy(busy),
    .link_strobe(link_strobe), .link_we(link_we), .link_addr(link_addr), .link_wdata(link_wdata),
    .link_ack(link_ack), .link_rdata(link_rdata), .link_ok(link_ok)
  );

  always #5 byte_clk = ~byte_clk;

  task automatic cyc();
    @(posedge byte_clk);
    #1;
  endtask

  // Remote-slave behaviour: ack ack_dly cycles after strobe, release rel_dly cycles after strobe drops.
  task automatic run_slave(input int ack_dly, input int rel_dly, input logic [31:0] rd);
    int n;
    obs_ok = 1'b1; obs_done = '0; obs_err = '0; obs_done_next = '0; obs_busy_next = 1'b0;
    n = 0;
    while (!link_strobe && n < 20) begin cyc(); n++; end
    if (!link_strobe) begin obs_ok = 1'b0; return; end
    obs_addr = link_addr; obs_wdata = link_wdata; obs_we = link_we;
    repeat (ack_dly) cyc();
    link_ack = 1'b1; link_rdata = rd;
    n = 0;
    while (link_strobe && n < 20) begin cyc(); n++; end
    if (link_strobe) begin obs_ok = 1'b0; link_ack = 1'b0; return; end
    repeat (rel_dly) cyc();
    link_ack = 1'b0;
    n = 0;
    do begin cyc(); n++; end while (done == '0 && err == '0 && n < 6);
    obs_done = done; obs_err = err; obs_rdata = rdata;
    if (done == '0 && err == '0) obs_ok = 1'b0;
    cyc();
    obs_done_next = done; obs_busy_next = busy;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    link_ack = 1'b0; link_ok = 1'b1; link_rdata = 32'h0;
    #12;
    checks++;
    if ({done, err, rdata, busy, link_strobe, link_we, link_addr, link_wdata} !== '0) begin
      errors++; $display("FAIL reset_outputs: got busy=%b strobe=%b addr=%h rdata=%h, need all 0",
                         busy, link_strobe, link_addr, rdata);
    end
    cyc(); reset_n = 1'b1; cyc(); cyc();
    checks++;
    if (busy !== 1'b0 || link_strobe !== 1'b0) begin
      errors++; $display("FAIL idle_no_req: got busy=%b strobe=%b, need 0 0", busy, link_strobe);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_order [5];
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
    req_we = 4'b0000; req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      run_slave(1, 1, 32'hA000_0000 | 32'(t));
      checks++;
      if (!obs_ok || obs_done !== exp_order[t]) begin
        errors++; $display("FAIL rr_grant%0d: got done=%b ok=%b, need %b", t, obs_done, obs_ok, exp_order[t]);
      end
      checks++;
      if (obs_rdata !== (32'hA000_0000 | 32'(t))) begin
        errors++; $display("FAIL rr_rdata%0d: got %h, need %h", t, obs_rdata, 32'hA000_0000 | 32'(t));
      end
    end
    req = '0;
  endtask

  task automatic test_single_write();
    req_we[1] = 1'b1; req_addr[16*1 +: 16] = 16'h0010; req_wdata[32*1 +: 32] = 32'hDEADBEEF;
    req = 4'b0010;
    run_slave(5, 3, 32'hFFFF_FFFF);
    req = '0;
    checks++;
    if (!obs_ok || obs_addr !== 16'h0010 || obs_wdata !== 32'hDEADBEEF || obs_we !== 1'b1) begin
      errors++; $display("FAIL wr_fields: got ok=%b addr=%h wdata=%h we=%b, need 0010 DEADBEEF 1",
                         obs_ok, obs_addr, obs_wdata, obs_we);
    end
    checks++;
    if (obs_done !== 4'b0010 || obs_err !== 4'b0000) begin
      errors++; $display("FAIL wr_done: got done=%b err=%b, need 0010 0000", obs_done, obs_err);
    end
    checks++;
    if (obs_done_next !== 4'b0000 || obs_busy_next !== 1'b0) begin
      errors++; $display("FAIL wr_pulse_end: got done=%b busy=%b, need 0000 0", obs_done_next, obs_busy_next);
    end
    checks++;
    if (obs_rdata !== 32'hA000_0004) begin
      errors++; $display("FAIL wr_rdata_hold: got %h, need A0000004", obs_rdata);
    end
    checks++;
    if (link_addr !== 16'h0010) begin
      errors++; $display("FAIL wr_addr_kept: got %h, need 0010", link_addr);
    end
  endtask

  task automatic test_single_read();
    req_we[2] = 1'b0; req_addr[16*2 +: 16] = 16'h0004;
    req = 4'b0100;
    run_slave(2, 2, 32'h12345678);
    req = '0;
    checks++;
    if (!obs_ok || obs_we !== 1'b0 || obs_addr !== 16'h0004) begin
      errors++; $display("FAIL rd_fields: got ok=%b we=%b addr=%h, need 1 0 0004", obs_ok, obs_we, obs_addr);
    end
    checks++;
    if (obs_done !== 4'b0100 || obs_rdata !== 32'h12345678) begin
      errors++; $display("FAIL rd_done: got done=%b rdata=%h, need 0100 12345678", obs_done, obs_rdata);
    end
  endtask

  task automatic test_timeout();
    int n, hi;
    req_we[3] = 1'b1; req = 4'b1000;
    n = 0;
    while (!link_strobe && n < 20) begin cyc(); n++; end
    hi = link_strobe ? 1 : 0;
    do begin cyc(); if (link_strobe) hi++; end while (link_strobe && hi < 40);
    req = '0;
    checks++;
    if (hi != 16) begin
      errors++; $display("FAIL to_strobe_len: got %0d cycles, need 16", hi);
    end
    checks++;
    if (err !== 4'b1000 || done !== 4'b0000) begin
      errors++; $display("FAIL to_err: got err=%b done=%b, need 1000 0000", err, done);
    end
    checks++;
    if (rdata !== 32'h12345678) begin
      errors++; $display("FAIL to_rdata_hold: got %h, need 12345678", rdata);
    end
    cyc();
    checks++;
    if (err !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("FAIL to_err_end: got err=%b busy=%b, need 0000 0", err, busy);
    end
    req_we[0] = 1'b1; req = 4'b0001;
    run_slave(2, 1, 32'h0);
    req = '0;
    checks++;
    if (!obs_ok || obs_done !== 4'b0001) begin
      errors++; $display("FAIL to_next_req: got done=%b ok=%b, need 0001", obs_done, obs_ok);
    end
  endtask

  task automatic test_link_loss();
    int n;
    logic bad;
    req = 4'b0010;
    n = 0;
    while (!link_strobe && n < 20) begin cyc(); n++; end
    link_ok = 1'b0;
    cyc();
    checks++;
    if (err !== 4'b0010 || link_strobe !== 1'b0 || done !== 4'b0000) begin
      errors++; $display("FAIL ll_err: got err=%b strobe=%b done=%b, need 0010 0 0000", err, link_strobe, done);
    end
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin cyc(); if (busy || link_strobe) bad = 1'b1; end
    checks++;
    if (bad !== 1'b0) begin
      errors++; $display("FAIL ll_no_grant_linkdown: got grant activity=%b, need 0", bad);
    end
    link_ok = 1'b1; link_ack = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 4; c++) begin cyc(); if (busy || link_strobe) bad = 1'b1; end
    checks++;
    if (bad !== 1'b0) begin
      errors++; $display("FAIL ll_no_grant_stale_ack: got grant activity=%b, need 0", bad);
    end
    link_ack = 1'b0;
    run_slave(1, 1, 32'h5555AAAA);
    req = '0;
    checks++;
    if (!obs_ok || obs_done !== 4'b0010) begin
      errors++; $display("FAIL ll_recover: got done=%b ok=%b, need 0010", obs_done, obs_ok);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    req = 4'b0100;
    n = 0;
    while (!link_strobe && n < 20) begin cyc(); n++; end
    cyc();
    link_ack = 1'b1; link_rdata = 32'hCAFE0001;
    n = 0;
    while (link_strobe && n < 20) begin cyc(); n++; end
    checks++;
    if (busy !== 1'b1 || link_strobe !== 1'b0) begin
      errors++; $display("FAIL mr_in_release: got busy=%b strobe=%b, need 1 0", busy, link_strobe);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({done, err, rdata, busy, link_strobe, link_we, link_addr, link_wdata} !== '0) begin
      errors++; $display("FAIL mr_async_clear: got busy=%b addr=%h rdata=%h, need all 0", busy, link_addr, rdata);
    end
    link_ack = 1'b0;
    cyc(); cyc();
    req = 4'b1111;
    reset_n = 1'b1;
    run_slave(1, 1, 32'h0);
    req = '0;
    checks++;
    if (!obs_ok || obs_done !== 4'b0001) begin
      errors++; $display("FAIL mr_first_grant: got done=%b ok=%b, need 0001", obs_done, obs_ok);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_write();
    test_single_read();
    test_timeout();
    test_link_loss();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
